// File: rtl/ifetch.sv
// Instruction fetch: PC register, credit-limited in-order word fetch, and a small
// {inst, pc} FIFO toward decode. Redirects flush the FIFO and drop stale responses.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_ent_t;

  logic [63:0]                  pc;
  fetch_ent_t [DEPTH-1:0]       fifo;
  logic [DEPTH-1:0][63:0]       pcq;
  logic [AW-1:0]                rd_ptr, wr_ptr, pq_rd, pq_wr;
  logic [CW-1:0]                count, outstanding, stale;
  logic [CW:0]                  credit_use;
  logic                         req_fire, deq, enq, drop;
  logic                         unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Credit covers both buffered entries and in-flight requests, so the FIFO can
  // never overflow even when stale responses are still on their way back.
  assign credit_use     = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(deq);
  assign imem_req_valid = !rst && !redirect_valid && (credit_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = rst ? RESET_PC : pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && (count != '0) && !redirect_valid;
  assign deq        = inst_valid && inst_ready;
  assign inst       = fifo[rd_ptr].inst;
  assign inst_pc    = fifo[rd_ptr].pc;

  assign enq  = imem_rsp_valid && !redirect_valid && (stale == '0);
  assign drop = imem_rsp_valid && !redirect_valid && (stale != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      if (redirect_valid)
        pc <= {redirect_pc[63:2], 2'b00};
      else if (req_fire)
        pc <= pc + 64'd4;

      if (req_fire)       pq_wr <= pq_wr + AW'(1);
      if (imem_rsp_valid) pq_rd <= pq_rd + AW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

      // A response landing in the redirect cycle is itself stale, hence the subtract.
      if (redirect_valid)
        stale <= outstanding - CW'(imem_rsp_valid);
      else if (drop)
        stale <= stale - CW'(1);

      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire) pcq[pq_wr] <= pc;
    if (enq && !rst) fifo[wr_ptr] <= '{inst: imem_rsp_data, pc: pcq[pq_rd]};
  end
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: fixed-latency in-order memory model, hand-computed
// addresses and instruction words (word = addr[31:0] | 3).
module tb_ifetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [63:0] imem_req_addr, redirect_pc, inst_pc;
  logic [31:0] imem_rsp_data, inst;

  logic        w_req_valid, w_inst_valid, w_ready, w_rsp_valid, w_redirect, w_inst_ready;
  logic [63:0] w_req_addr, w_inst_pc, w_redirect_pc;
  logic [31:0] w_inst, w_rsp_data;

  ifetch #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  ifetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  int checks = 0, errors = 0;
  int cyc = 0, lat = 1;
  logic [63:0] p_addr[$];
  int          p_due[$];
  logic [63:0] acc_log[$], dl_pc[$];
  logic [31:0] dl_inst[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes, advance, then drive this cycle's memory response.
  task automatic tick();
    logic acc, r;
    logic [63:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    r   = rst;
    if (inst_valid && inst_ready) begin
      dl_pc.push_back(inst_pc);
      dl_inst.push_back(inst);
    end
    if (acc) acc_log.push_back(a);
    @(posedge clk);
    cyc++;
    #1;
    if (r) begin
      p_addr.delete();
      p_due.delete();
    end else if (acc) begin
      p_addr.push_back(a);
      p_due.push_back(cyc - 1 + lat);
    end
    if (p_addr.size() > 0 && p_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = p_addr[0][31:0] | 32'h3;
      void'(p_addr.pop_front());
      void'(p_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    acc_log.delete();
    dl_pc.delete();
    dl_inst.delete();
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    w_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0; w_redirect = 1'b0;
    w_redirect_pc = '0; w_inst_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_req_addr", imem_req_addr, 64'h1000);

    // Reset start + wrap instance
    lat = 1; inst_ready = 1'b1;
    do_reset();
    chk("start_c0_valid", imem_req_valid, 1);
    chk("start_c0_addr", imem_req_addr, 64'h1000);
    chk("start_c0_inst_valid", inst_valid, 0);
    chk("wrap_c0_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("start_c1_addr", imem_req_addr, 64'h1004);
    chk("start_c1_inst_valid", inst_valid, 0);
    chk("wrap_c1_valid", w_req_valid, 1);
    chk("wrap_c1_addr", w_req_addr, 64'h0);
    tick();
    chk("start_c2_inst_valid", inst_valid, 1);
    chk("start_c2_inst_pc", inst_pc, 64'h1000);
    chk("start_c2_inst", inst, 64'h1003);
    chk("start_c2_addr", imem_req_addr, 64'h1008);
    tick();
    chk("start_c3_inst_pc", inst_pc, 64'h1004);
    chk("start_c3_inst", inst, 64'h1007);
    chk("start_c3_addr", imem_req_addr, 64'h100C);

    // Backpressure
    inst_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("bp_c4_req_valid", imem_req_valid, 0);
    chk("bp_c4_inst_valid", inst_valid, 1);
    chk("bp_c4_inst_pc", inst_pc, 64'h1000);
    chk("bp_accepted", acc_log.size(), 4);
    repeat (3) tick();
    chk("bp_c7_req_valid", imem_req_valid, 0);
    dl_pc.delete(); dl_inst.delete();
    inst_ready = 1'b1;
    #1;
    chk("bp_resume_valid", imem_req_valid, 1);
    chk("bp_resume_addr", imem_req_addr, 64'h1010);
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      if (i < dl_pc.size()) begin
        chk($sformatf("bp_drain_pc%0d", i), dl_pc[i], 64'h1000 + 64'(4 * i));
        chk($sformatf("bp_drain_inst%0d", i), dl_inst[i], 64'h1003 + 64'(4 * i));
      end else chk($sformatf("bp_drain_missing%0d", i), 0, 1);
    end

    // Redirect with two fetches in flight
    lat = 3; inst_ready = 1'b1;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    #1;
    chk("redir_req_valid", imem_req_valid, 0);
    chk("redir_inst_valid", inst_valid, 0);
    acc_log.delete(); dl_pc.delete(); dl_inst.delete();
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_next_valid", imem_req_valid, 1);
    chk("redir_next_addr", imem_req_addr, 64'h2000);
    for (int i = 0; i < 12 && dl_pc.size() == 0; i++) tick();
    if (dl_pc.size() == 0) chk("redir_timeout", 0, 1);
    else begin
      chk("redir_first_pc", dl_pc[0], 64'h2000);
      chk("redir_first_inst", dl_inst[0], 64'h2003);
      chk("redir_first_acc", acc_log[0], 64'h2000);
    end

    // Redirect in the same cycle as a response
    lat = 2; inst_ready = 1'b0;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    #1;
    chk("samecyc_inst_valid", inst_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("samecyc_not_enq", inst_valid, 0);
    chk("samecyc_addr", imem_req_addr, 64'h3000);
    tick();
    chk("samecyc_stale_drop", inst_valid, 0);
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    chk("samecyc_valid", inst_valid, 1);
    chk("samecyc_first_pc", inst_pc, 64'h3000);

    // Memory stall
    lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid%0d", i), imem_req_valid, 1);
      chk($sformatf("stall_addr%0d", i), imem_req_addr, 64'h1000);
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    chk("stall_release_addr", imem_req_addr, 64'h1000);
    tick();
    chk("stall_advance_addr", imem_req_addr, 64'h1004);

    // Reset mid-stream with a full FIFO
    inst_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    chk("midrst_full", inst_valid, 1);
    chk("midrst_blocked", imem_req_valid, 0);
    rst = 1'b1;
    #1;
    chk("midrst_rst_req_valid", imem_req_valid, 0);
    chk("midrst_rst_inst_valid", inst_valid, 0);
    chk("midrst_rst_addr", imem_req_addr, 64'h1000);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_after_inst_valid", inst_valid, 0);
    chk("midrst_after_req_valid", imem_req_valid, 1);
    chk("midrst_after_addr", imem_req_addr, 64'h1000);
    tick(); tick();
    chk("midrst_refill_valid", inst_valid, 1);
    chk("midrst_refill_pc", inst_pc, 64'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
